// File: rtl/cci_mpf_rd_client_arb.sv
// Read-request arbiter for the MPF c0 channel.
// Round-robin shares one c0 read port among N_CLIENTS requesters. It keeps a
// per-client and a global count of outstanding lines, freed by returned
// responses, and has a drain sequencer that quiesces all reads on request.
//
// state  | meaning
// RUN    | normal arbitration, grants allowed
// DRAIN  | grants blocked, waiting for outstanding lines to return
// DONE   | quiesced, drain_done_o high until drain_req_i drops

module cci_mpf_rd_client_arb #(
    parameter int N_CLIENTS      = 4,
    parameter int ADDR_W         = 42,
    parameter int TAG_W          = 8,
    parameter int MAX_PER_CLIENT = 64,
    parameter int MAX_ACTIVE     = 256,
    localparam int CLIENT_W      = $clog2(N_CLIENTS),
    localparam int ACTIVE_W      = $clog2(MAX_ACTIVE) + 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [N_CLIENTS-1:0]          req_valid_i,
    input  logic [N_CLIENTS*ADDR_W-1:0]   req_addr_i,
    input  logic [N_CLIENTS*TAG_W-1:0]    req_tag_i,
    output logic [N_CLIENTS-1:0]          req_ready_o,
    output logic                          out_valid_o,
    output logic [ADDR_W-1:0]             out_addr_o,
    output logic [CLIENT_W-1:0]           out_client_o,
    output logic [TAG_W-1:0]              out_tag_o,
    input  logic                          out_almost_full_i,
    input  logic                          rsp_valid_i,
    input  logic [CLIENT_W-1:0]           rsp_client_i,
    input  logic                          drain_req_i,
    output logic                          drain_done_o,
    output logic [ACTIVE_W-1:0]           active_cnt_o,
    output logic                          credit_err_o
);

    localparam int PC_W = $clog2(MAX_PER_CLIENT) + 1;
    localparam logic [PC_W-1:0]     PC_MAX   = PC_W'(MAX_PER_CLIENT);
    localparam logic [ACTIVE_W-1:0] ACT_MAX  = ACTIVE_W'(MAX_ACTIVE);
    localparam logic [CLIENT_W:0]   N_WRAP   = (CLIENT_W + 1)'(N_CLIENTS);
    localparam logic [CLIENT_W-1:0] LAST_IDX = CLIENT_W'(N_CLIENTS - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 state_q;
    logic                   drain_done_q;

    logic [PC_W-1:0]        cnt_q [N_CLIENTS];
    logic [PC_W-1:0]        cnt_d [N_CLIENTS];
    logic [ACTIVE_W-1:0]    active_q, active_d;
    logic [CLIENT_W-1:0]    ptr_q, ptr_d;

    logic                   out_valid_q;
    logic [ADDR_W-1:0]      out_addr_q;
    logic [CLIENT_W-1:0]    out_client_q;
    logic [TAG_W-1:0]       out_tag_q;
    logic                   credit_err_q;

    logic                   grant_ok;
    logic [N_CLIENTS-1:0]   elig;
    logic                   grant_vld;
    logic [CLIENT_W-1:0]    grant_idx;
    logic [N_CLIENTS-1:0]   grant_oh;
    logic [CLIENT_W:0]      rr_idx;
    logic [ADDR_W-1:0]      sel_addr;
    logic [TAG_W-1:0]       sel_tag;

    logic [N_CLIENTS-1:0]   rsp_hit;
    logic                   rsp_ok;

    // Per-client eligibility; reset gating keeps req_ready low while in reset
    always_comb begin
        grant_ok = !reset_i && (state_q == ST_RUN) && !drain_req_i &&
                   !out_almost_full_i && (active_q < ACT_MAX);
        elig = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            elig[i] = grant_ok && req_valid_i[i] && (cnt_q[i] < PC_MAX);
        end
    end

    // Round-robin search starting at the pointer, wrapping modulo N_CLIENTS
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        rr_idx    = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            rr_idx = {1'b0, ptr_q} + (CLIENT_W + 1)'(k);
            if (rr_idx >= N_WRAP) begin
                rr_idx = rr_idx - N_WRAP;
            end
            if (!grant_vld && elig[rr_idx[CLIENT_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = rr_idx[CLIENT_W-1:0];
            end
        end
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    // Payload mux for the granted client
    always_comb begin
        sel_addr = '0;
        sel_tag  = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if (grant_oh[k]) begin
                sel_addr = req_addr_i[k*ADDR_W +: ADDR_W];
                sel_tag  = req_tag_i[k*TAG_W +: TAG_W];
            end
        end
    end

    // Response decode; a response for an idle or nonexistent client frees nothing
    always_comb begin
        rsp_hit = '0;
        rsp_ok  = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            rsp_hit[i] = rsp_valid_i && (rsp_client_i == CLIENT_W'(i));
            if (rsp_hit[i] && (cnt_q[i] != '0)) begin
                rsp_ok = 1'b1;
            end
        end
    end

    // Credit counter next-state; same-client grant+response nets to zero
    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant_oh[i] && !(rsp_hit[i] && (cnt_q[i] != '0))) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!grant_oh[i] && rsp_hit[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        active_d = active_q;
        if (grant_vld && !rsp_ok) begin
            active_d = active_q + 1'b1;
        end else if (!grant_vld && rsp_ok) begin
            active_d = active_q - 1'b1;
        end
    end

    // Accounting, pointer, output register and sticky credit error
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                cnt_q[i] <= '0;
            end
            active_q     <= '0;
            ptr_q        <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_client_q <= '0;
            out_tag_q    <= '0;
            credit_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            active_q    <= active_d;
            ptr_q       <= ptr_d;
            out_valid_q <= grant_vld;
            if (grant_vld) begin
                out_addr_q   <= sel_addr;
                out_client_q <= grant_idx;
                out_tag_q    <= sel_tag;
            end
            if (rsp_valid_i && !rsp_ok) begin
                credit_err_q <= 1'b1;
            end
        end
    end

    // Drain sequencer with registered drain_done
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_RUN;
            drain_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (drain_req_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!drain_req_i) begin
                        state_q <= ST_RUN;
                    end else if ((active_q == '0) && !out_valid_q) begin
                        state_q      <= ST_DONE;
                        drain_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!drain_req_i) begin
                        state_q      <= ST_RUN;
                        drain_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_RUN;
                    drain_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = grant_oh;
    assign out_valid_o  = out_valid_q;
    assign out_addr_o   = out_addr_q;
    assign out_client_o = out_client_q;
    assign out_tag_o    = out_tag_q;
    assign drain_done_o = drain_done_q;
    assign active_cnt_o = active_q;
    assign credit_err_o = credit_err_q;

endmodule

// File: tb/tb_cci_mpf_rd_client_arb.sv
// Directed bench for cci_mpf_rd_client_arb with small credit limits
// (6 lines per client, 8 lines total) so the limits are reached quickly.

module tb_cci_mpf_rd_client_arb;

    localparam int N   = 4;
    localparam int AW  = 42;
    localparam int TW  = 8;
    localparam int MPC = 6;
    localparam int MA  = 8;
    localparam int CW  = 2;
    localparam int ACW = 4;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [N-1:0]      req_valid_i;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*TW-1:0]   req_tag_i;
    logic [N-1:0]      req_ready_o;
    logic              out_valid_o;
    logic [AW-1:0]     out_addr_o;
    logic [CW-1:0]     out_client_o;
    logic [TW-1:0]     out_tag_o;
    logic              out_almost_full_i;
    logic              rsp_valid_i;
    logic [CW-1:0]     rsp_client_i;
    logic              drain_req_i;
    logic              drain_done_o;
    logic [ACW-1:0]    active_cnt_o;
    logic              credit_err_o;

    int total = 0;
    int bad   = 0;
    int n;
    int dl [5] = '{1, 2, 2, 3, 3};

    cci_mpf_rd_client_arb #(
        .N_CLIENTS      (N),
        .ADDR_W         (AW),
        .TAG_W          (TW),
        .MAX_PER_CLIENT (MPC),
        .MAX_ACTIVE     (MA)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .req_valid_i       (req_valid_i),
        .req_addr_i        (req_addr_i),
        .req_tag_i         (req_tag_i),
        .req_ready_o       (req_ready_o),
        .out_valid_o       (out_valid_o),
        .out_addr_o        (out_addr_o),
        .out_client_o      (out_client_o),
        .out_tag_o         (out_tag_o),
        .out_almost_full_i (out_almost_full_i),
        .rsp_valid_i       (rsp_valid_i),
        .rsp_client_i      (rsp_client_i),
        .drain_req_i       (drain_req_i),
        .drain_done_o      (drain_done_o),
        .active_cnt_o      (active_cnt_o),
        .credit_err_o      (credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rsp(input int c);
        rsp_valid_i  = 1'b1;
        rsp_client_i = CW'(c);
        tick();
        rsp_valid_i  = 1'b0;
    endtask

    initial begin
        reset_i           = 1'b1;
        req_valid_i       = 4'hF;
        out_almost_full_i = 1'b0;
        rsp_valid_i       = 1'b0;
        rsp_client_i      = '0;
        drain_req_i       = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW] = AW'(64'h100 + 64'(i));
            req_tag_i[i*TW +: TW]  = TW'(8'hA0 + 8'(i));
        end

        // reset state
        #2;
        chk("rst_out_valid",  64'(out_valid_o),  64'd0);
        chk("rst_active",     64'(active_cnt_o), 64'd0);
        chk("rst_credit_err", 64'(credit_err_o), 64'd0);
        chk("rst_drain_done", 64'(drain_done_o), 64'd0);
        chk("rst_req_ready",  64'(req_ready_o),  64'd0);
        #10;
        reset_i = 1'b0;
        #1;

        // round robin 0,1,2 with 1-cycle output latency
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rr_ready_%0d", k), 64'(req_ready_o), 64'd1 << k);
            tick();
            chk($sformatf("rr_oval_%0d", k),   64'(out_valid_o),  64'd1);
            chk($sformatf("rr_client_%0d", k), 64'(out_client_o), 64'(k));
            chk($sformatf("rr_addr_%0d", k),   64'(out_addr_o),   64'h100 + 64'(k));
            chk($sformatf("rr_tag_%0d", k),    64'(out_tag_o),    64'hA0 + 64'(k));
            chk($sformatf("rr_active_%0d", k), 64'(active_cnt_o), 64'(k + 1));
            #1;
        end

        // almost-full throttle for 10 cycles
        out_almost_full_i = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("af_ready_%0d", k), 64'(req_ready_o), 64'd0);
            tick();
            chk($sformatf("af_oval_%0d", k), 64'(out_valid_o), 64'd0);
            #1;
        end
        chk("af_active",    64'(active_cnt_o), 64'd3);
        chk("af_addr_hold", 64'(out_addr_o),   64'h102);
        out_almost_full_i = 1'b0;
        #1;

        // resumes at client 3, continues until the global limit of 8
        for (int k = 3; k < 8; k++) begin
            chk($sformatf("rr2_ready_%0d", k), 64'(req_ready_o), 64'd1 << (k % 4));
            tick();
            chk($sformatf("rr2_oval_%0d", k),   64'(out_valid_o),  64'd1);
            chk($sformatf("rr2_client_%0d", k), 64'(out_client_o), 64'(k % 4));
            chk($sformatf("rr2_active_%0d", k), 64'(active_cnt_o), 64'(k + 1));
            #1;
        end
        chk("glob_ready", 64'(req_ready_o), 64'd0);
        tick();
        chk("glob_oval",   64'(out_valid_o),  64'd0);
        chk("glob_active", 64'(active_cnt_o), 64'd8);
        chk("glob_addr",   64'(out_addr_o),   64'h103);
        chk("glob_tag",    64'(out_tag_o),    64'hA3);

        // same-cycle grant and response for client 1
        req_valid_i = 4'h0;
        rsp(1);
        chk("rsp1_active", 64'(active_cnt_o), 64'd7);
        req_valid_i  = 4'b0010;
        rsp_valid_i  = 1'b1;
        rsp_client_i = 2'd1;
        #1;
        chk("same_ready", 64'(req_ready_o), 64'b0010);
        tick();
        rsp_valid_i = 1'b0;
        chk("same_oval",   64'(out_valid_o),  64'd1);
        chk("same_client", 64'(out_client_o), 64'd1);
        chk("same_active", 64'(active_cnt_o), 64'd7);
        #1;
        chk("c1_ready", 64'(req_ready_o), 64'b0010);
        tick();
        chk("c1_active", 64'(active_cnt_o), 64'd8);
        #1;
        chk("glob2_ready", 64'(req_ready_o), 64'd0);

        // bring outstanding down to 5, then drain
        req_valid_i = 4'h0;
        rsp(0);
        rsp(0);
        rsp(1);
        chk("pre_drain_active", 64'(active_cnt_o), 64'd5);
        drain_req_i = 1'b1;
        req_valid_i = 4'hF;
        #1;
        chk("drain_ready", 64'(req_ready_o), 64'd0);
        for (int j = 0; j < 5; j++) begin
            rsp(dl[j]);
            chk($sformatf("drain_active_%0d", j), 64'(active_cnt_o), 64'(4 - j));
            chk($sformatf("drain_done0_%0d", j),  64'(drain_done_o), 64'd0);
        end
        tick();
        chk("drain_done_set", 64'(drain_done_o), 64'd1);
        tick();
        chk("drain_done_hold", 64'(drain_done_o), 64'd1);
        chk("drain_oval",      64'(out_valid_o),  64'd0);
        drain_req_i = 1'b0;
        #1;
        chk("done_ready", 64'(req_ready_o), 64'd0);
        tick();
        chk("drain_done_clr", 64'(drain_done_o), 64'd0);
        #1;
        chk("resume_ready", 64'(req_ready_o), 64'b0100);
        tick();
        chk("resume_client", 64'(out_client_o), 64'd2);
        chk("resume_active", 64'(active_cnt_o), 64'd1);

        // per-client limit on client 2
        req_valid_i = 4'b0100;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (req_ready_o[2]) n++;
            tick();
        end
        chk("pc_grants", 64'(n), 64'd5);
        #1;
        chk("pc_ready",  64'(req_ready_o),  64'd0);
        chk("pc_active", 64'(active_cnt_o), 64'd6);
        req_valid_i = 4'b0101;
        #1;
        chk("pc_skip_ready", 64'(req_ready_o), 64'b0001);
        tick();
        chk("pc_skip_client", 64'(out_client_o), 64'd0);
        chk("pc_skip_active", 64'(active_cnt_o), 64'd7);
        req_valid_i  = 4'b0100;
        rsp_valid_i  = 1'b1;
        rsp_client_i = 2'd2;
        #1;
        chk("pc_rsp_ready", 64'(req_ready_o), 64'd0);
        tick();
        rsp_valid_i = 1'b0;
        chk("pc_rsp_active", 64'(active_cnt_o), 64'd6);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (req_ready_o[2]) n++;
            tick();
        end
        chk("pc_one_more", 64'(n), 64'd1);
        chk("pc_one_active", 64'(active_cnt_o), 64'd7);

        // response for idle client 3
        req_valid_i = 4'h0;
        rsp(3);
        chk("cerr_set",    64'(credit_err_o), 64'd1);
        chk("cerr_active", 64'(active_cnt_o), 64'd7);
        tick();
        chk("cerr_sticky", 64'(credit_err_o), 64'd1);

        // three outstanding with a request in flight, then async reset
        rsp(2);
        rsp(2);
        rsp(2);
        rsp(2);
        chk("mid_active", 64'(active_cnt_o), 64'd3);
        req_valid_i  = 4'b0001;
        rsp_valid_i  = 1'b1;
        rsp_client_i = 2'd2;
        tick();
        rsp_valid_i = 1'b0;
        req_valid_i = 4'h0;
        chk("mid_oval",   64'(out_valid_o),  64'd1);
        chk("mid_client", 64'(out_client_o), 64'd0);
        chk("mid_active2", 64'(active_cnt_o), 64'd3);
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_oval",       64'(out_valid_o),  64'd0);
        chk("arst_active",     64'(active_cnt_o), 64'd0);
        chk("arst_credit_err", 64'(credit_err_o), 64'd0);
        chk("arst_drain_done", 64'(drain_done_o), 64'd0);
        #1;
        reset_i = 1'b0;
        req_valid_i = 4'hF;
        #1;
        chk("post_rst_ready", 64'(req_ready_o), 64'b0001);
        req_valid_i  = 4'h0;
        rsp_valid_i  = 1'b1;
        rsp_client_i = 2'd0;
        tick();
        rsp_valid_i = 1'b0;
        chk("post_rst_cerr",   64'(credit_err_o), 64'd1);
        chk("post_rst_active", 64'(active_cnt_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cci_mpf_rd_client_arb.md
Name: cci_mpf_rd_client_arb

Overview:
- Shares one MPF c0 read-request channel among N_CLIENTS independent requesters.
- Round-robin arbitration under the downstream almost-full throttle.
- Enforces a per-client and a global limit on outstanding read lines, using returned responses to free credits.
- Provides a drain sequencer so software or a parent shim can quiesce all reads (e.g. before a fence or reconfiguration). Sits between AFU-side clients and the MPF c0Tx/c0Rx edge.

Parameters:
N_CLIENTS, 4, number of requesters (2..16)
ADDR_W, 42, line address width
TAG_W, 8, client-private tag width carried to output
MAX_PER_CLIENT, 64, max outstanding lines per client
MAX_ACTIVE, 256, max outstanding lines across all clients (>= MAX_PER_CLIENT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  N_CLIENTS  per-client request valid
req_addr  in  N_CLIENTS*ADDR_W  per-client line address, client i at [i*ADDR_W +: ADDR_W]
req_tag  in  N_CLIENTS*TAG_W  per-client tag
req_ready  out  N_CLIENTS  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
out_valid  out  1  registered request to c0 channel
out_addr  out  ADDR_W  granted address
out_client  out  $clog2(N_CLIENTS)  granted client id (placed in mdata by the parent)
out_tag  out  TAG_W  granted tag
out_almost_full  in  1  c0TxAlmFull from downstream
rsp_valid  in  1  one read-line response returned
rsp_client  in  $clog2(N_CLIENTS)  client id recovered from response mdata
drain_req  in  1  level; request quiesce
drain_done  out  1  level; no grants and zero outstanding while draining
active_cnt  out  $clog2(MAX_ACTIVE)+1  total outstanding lines
credit_err  out  1  sticky; response arrived for a client with zero outstanding

Behaviour:
- Reset (async assert, synchronous release by clk):
  - All per-client counters, active_cnt, out_valid, credit_err and drain_done = 0.
  - RR pointer = 0; FSM = RUN; req_ready = 0.
- Eligibility: client i is eligible when req_valid[i], cnt[i] < MAX_PER_CLIENT, active_cnt < MAX_ACTIVE, !out_almost_full and FSM == RUN.
- req_ready is combinational from eligibility and the RR pointer.
- Grant: at most one per cycle. The first eligible client is searched starting at the RR pointer, wrapping modulo N_CLIENTS. On grant, the pointer becomes (granted+1) mod N_CLIENTS; otherwise it is unchanged.
- Latency: accepted request appears on out_* the next cycle with out_valid=1; out_valid=0 in cycles with no grant. out_* data holds its last value when out_valid=0.
- Almost-full: sampled the same cycle as the grant decision. The downstream absorbs in-flight slack, as in standard CCI almost-full semantics.
- Counters, updated on the grant cycle and on rsp_valid:
  - Grant increments cnt[granted] and active_cnt.
  - rsp_valid decrements cnt[rsp_client] and active_cnt.
  - Grant and response on the same client in one cycle: net 0. On different clients: each counter adjusts, and active_cnt is unchanged.
- Error response: rsp_valid with cnt[rsp_client]==0 sets credit_err (sticky until reset). Counters must not underflow (saturate at 0). rsp_client >= N_CLIENTS is treated the same way.
- FSM:
  - RUN -> DRAIN when drain_req=1. Grants stop the same cycle drain_req is sampled high, and req_ready=0.
  - DRAIN -> DONE when active_cnt==0 and out_valid==0. Entering DONE registers drain_done=1.
  - DRAIN -> RUN if drain_req drops before completion.
  - DONE holds drain_done=1 and no grants while drain_req=1. DONE -> RUN when drain_req=0; drain_done clears the same edge.
- Boundary conditions:
  - A client at MAX_PER_CLIENT is skipped; others still get grants.
  - At active_cnt==MAX_ACTIVE, no client is granted.
  - active_cnt never exceeds MAX_ACTIVE.
- Reset mid-operation discards all outstanding accounting. Responses arriving after reset release count as credit_err cases.

Test Plan:
- N=4, all clients valid continuously, no throttle, ample credits -> grant order 0,1,2,3,0,1…; out_valid every cycle from cycle 1 after reset release; out_client matches grant with 1-cycle latency.
- Client 2 only, no responses, MAX_PER_CLIENT=64 -> exactly 64 grants, then req_ready[2]=0 indefinitely. One rsp_valid with rsp_client=2 -> exactly one further grant.
- MAX_ACTIVE=8, MAX_PER_CLIENT=4, all clients valid, no responses -> 8 grants total, active_cnt=8, then none. Same-cycle grant to client 1 with response for client 1 -> cnt[1] and active_cnt unchanged.
- out_almost_full held high 10 cycles mid-stream -> zero grants in those cycles; RR pointer preserved and arbitration resumes at the next client in order.
- 5 outstanding, assert drain_req -> req_ready=0 immediately. Return 5 responses -> drain_done=1 one cycle after active_cnt reaches 0. Deassert drain_req -> drain_done=0 and grants resume next cycle.
- rsp_valid for client 3 with cnt[3]=0 -> credit_err=1, counters stay 0. Assert reset asynchronously mid-stream with 3 outstanding -> out_valid, active_cnt, credit_err and drain_done all 0 immediately.
